// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential IEEE-754 single-precision divider.
// The 24-bit significands are divided by radix-2 restoring division, one
// quotient bit per clock for 27 clocks. One more clock normalizes, rounds
// to nearest-even and packs the result, and a final clock pulses done.
// Denormal inputs are flushed to zero and denormal results flush to zero.
// The latency is a fixed 29 clocks from the accepted start edge.
module fdiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf,
  output logic        unf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t state;
  logic [4:0] cnt;

  // Operands captured on the accepted start edge
  logic               sgn_p0;
  logic               zx1_p0;
  logic               zx2_p0;
  logic signed [9:0]  exp_p0;
  logic [23:0]        div_p0;

  // Iterating partial remainder and quotient
  logic [25:0] rem_p1;
  logic [26:0] quo_p1;

  logic        ge;
  logic [25:0] rem_nxt;
  logic [33:0] res;

  // Normalize the 27-bit quotient, round to nearest-even with guard, round
  // and sticky, then pack. Returns {ovf, unf, y}.
  function automatic logic [33:0] round_pack(
    input logic              sgn,
    input logic signed [9:0] e_in,
    input logic [26:0]       q,
    input logic              rnz
  );
    logic [23:0]       man;
    logic              g;
    logic              r;
    logic              s;
    logic              up;
    logic [24:0]       sum;
    logic signed [9:0] e;
    if (q[26]) begin
      man = q[26:3];
      g   = q[2];
      r   = q[1];
      s   = q[0] | rnz;
      e   = e_in;
    end else begin
      // Quotient below 1.0: one extra bit of precision is already available
      man = q[25:2];
      g   = q[1];
      r   = q[0];
      s   = rnz;
      e   = e_in - 10'sd1;
    end
    up  = g & (r | s | man[0]);
    sum = {1'b0, man} + {24'd0, up};
    if (sum[24]) begin
      man = sum[24:1];
      e   = e + 10'sd1;
    end else begin
      man = sum[23:0];
    end
    if (e >= 10'sd255)
      return {1'b1, 1'b0, sgn, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      return {1'b0, 1'b1, sgn, 31'd0};
    else
      return {1'b0, 1'b0, sgn, e[7:0], man[22:0]};
  endfunction

  // Special operands take priority over the arithmetic result.
  function automatic logic [33:0] select_result(
    input logic              sgn,
    input logic              zx1,
    input logic              zx2,
    input logic signed [9:0] e_in,
    input logic [26:0]       q,
    input logic              rnz
  );
    if (zx1)
      return {1'b0, 1'b0, sgn, 31'd0};
    else if (zx2)
      return {1'b1, 1'b0, sgn, 8'hFF, 23'd0};
    else
      return round_pack(sgn, e_in, q, rnz);
  endfunction

  // One restoring-division step: trial subtract of the divisor
  always_comb begin
    ge      = (rem_p1 >= {2'b00, div_p0});
    rem_nxt = ge ? (rem_p1 - {2'b00, div_p0}) : rem_p1;
    res     = select_result(sgn_p0, zx1_p0, zx2_p0, exp_p0, quo_p1,
                            (rem_p1 != 26'd0));
  end

  // Control FSM with registered outputs; y/ovf/unf update only in ROUND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= 32'd0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= 5'd0;
          end
        end
        CALC: begin
          if (cnt == 5'd26)
            state <= ROUND;
          else
            cnt <= cnt + 5'd1;
        end
        ROUND: begin
          ovf   <= res[33];
          unf   <= res[32];
          y     <= res[31:0];
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: capture operands on accept, iterate the division in CALC
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sgn_p0 <= x1[31] ^ x2[31];
      zx1_p0 <= (x1[30:23] == 8'd0);
      zx2_p0 <= (x2[30:23] == 8'd0);
      exp_p0 <= $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]})
                + 10'sd127;
      div_p0 <= {1'b1, x2[22:0]};
      rem_p1 <= {2'b00, 1'b1, x1[22:0]};
      quo_p1 <= 27'd0;
    end else if (state == CALC) begin
      // stage boundary: one quotient bit per clock
      rem_p1 <= {rem_nxt[24:0], 1'b0};
      quo_p1 <= {quo_p1[25:0], ge};
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Testbench for fdiv_seq: directed table, hand-written multi-cycle
// sequences (ignored start, mid-operation reset) and random operands
// compared with an exact-arithmetic reference model.
module tb_fdiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [31:0] y;
  logic        ovf;
  logic        unf;
  logic        busy;
  logic        done;

  int n_pass;
  int n_total;

  fdiv_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x1   (x1),
    .x2   (x2),
    .y    (y),
    .ovf  (ovf),
    .unf  (unf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Exact quotient of the significands via integer divide and remainder,
  // rounded to nearest-even by comparing twice the remainder to the divisor.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   sgn;
    int     ea;
    int     eb;
    int     e;
    longint ma;
    longint mb;
    longint n;
    longint s;
    longint r;
    logic [31:0] yy;
    sgn = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    if (ea == 0) return {2'b00, sgn, 31'd0};
    if (eb == 0) return {2'b10, sgn, 31'h7F800000};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = ea - eb + 127;
    if (ma < mb) begin
      ma = ma * 2;
      e  = e - 1;
    end
    n = ma * (64'd1 << 23);
    s = n / mb;
    r = n % mb;
    if (2 * r > mb || (2 * r == mb && s[0])) s = s + 1;
    if (s == (64'd1 << 24)) begin
      s = s / 2;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, sgn, 31'h7F800000};
    if (e <= 0)   return {2'b01, sgn, 31'd0};
    yy = {sgn, e[7:0], s[22:0]};
    return {2'b00, yy};
  endfunction

  // Issue one division and check latency, busy and the result.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [33:0] exp, input string nm);
    int lat;
    @(negedge clk);
    x1 = a;
    x2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd29);
    chk({nm, "_result"}, 64'({ovf, unf, y}), 64'(exp));
    @(negedge clk);
    chk({nm, "_idle"}, 64'({busy, done}), 64'd0);
  endtask

  function automatic logic [31:0] rnd_f();
    logic [7:0] e;
    if ($urandom_range(0, 15) == 0) e = 8'd0;
    else e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    int ndone;
    int lat_seen;
    logic [33:0] ea;
    logic [31:0] ra;
    logic [31:0] rb;
    n_pass  = 0;
    n_total = 0;
    rst   = 1'b1;
    start = 1'b0;
    x1    = 32'd0;
    x2    = 32'd0;

    tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    tbl[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0};
    tbl[2] = '{32'hC0000000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0};
    tbl[3] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0};
    tbl[4] = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1};
    tbl[5] = '{32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    tbl[6] = '{32'h3F800000, 32'hC0000000, 32'hBF000000, 1'b0, 1'b0};
    tbl[7] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_state", 64'({y, ovf, unf, busy, done}), 64'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++)
      run_div(tbl[i].a, tbl[i].b, {tbl[i].ovf, tbl[i].unf, tbl[i].y},
              $sformatf("vec%0d", i));

    // Second start during the operation must be ignored
    @(negedge clk);
    x1 = 32'h40C00000;
    x2 = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    lat_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (lat_seen == 0) lat_seen = c;
      end
      @(negedge clk);
    end
    chk("ignore_start_dones", 64'(ndone), 64'd1);
    chk("ignore_start_latency", 64'(lat_seen), 64'd29);
    chk("ignore_start_result", 64'({ovf, unf, y}), 64'({2'b00, 32'h40400000}));

    // Reset in the middle of an operation
    @(negedge clk);
    x1 = 32'h3F800000;
    x2 = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_clear", 64'({y, ovf, unf, busy, done}), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    rst = 1'b0;
    run_div(32'h3F800000, 32'h40400000, {2'b00, 32'h3EAAAAAB}, "after_rst");

    // Random operands against the reference model
    for (int k = 0; k < 150; k++) begin
      ra = rnd_f();
      rb = rnd_f();
      ea = model(ra, rb);
      run_div(ra, rb, ea, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fdiv_seq.md
FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port x1, input, 32 bits: dividend, IEEE-754 single; captured on the accepted start edge.
REQ-005 SHALL have port x2, input, 32 bits: divisor, IEEE-754 single; captured on the accepted start edge.
REQ-006 SHALL have port y, output, 32 bits: quotient x1/x2, registered.
REQ-007 SHALL have port ovf, output, 1 bit: overflow or divide-by-zero flag for the current y.
REQ-008 SHALL have port unf, output, 1 bit: underflow flag for the current y.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking that y, ovf and unf are valid.

Function
REQ-011 SHALL implement the FSM IDLE -> CALC -> ROUND -> DONE -> IDLE.
REQ-012 SHALL leave IDLE only on start=1, capturing x1 and x2 on that edge.
REQ-013 SHALL ignore start while busy=1; captured operands SHALL NOT change mid-operation.
REQ-014 SHALL stay in CALC exactly 27 cycles, producing one quotient bit per cycle by radix-2 restoring division of the 24-bit significands (hidden 1 included).
REQ-015 SHALL stay in ROUND 1 cycle: normalize, round, pack and register y, ovf and unf.
REQ-016 SHALL stay in DONE 1 cycle, with done=1 only in DONE, then return to IDLE.
REQ-017 SHALL assert done in the 29th cycle after the start-accept edge, giving a fixed latency of 29 cycles.
REQ-018 SHALL form the sign as x1[31] XOR x2[31] for every result, including special cases.
REQ-019 SHALL compute the biased exponent as e1 - e2 + 127 in at least 10-bit signed arithmetic.
REQ-020 SHALL, when the significand quotient is below 1.0, shift it left by 1 and subtract 1 from the exponent.
REQ-021 SHALL round to nearest, ties to even, using guard, round and sticky bits; sticky is the OR of the remainder being nonzero and any dropped bits.
REQ-022 SHALL, when rounding carries out of the significand, renormalize and add 1 to the exponent.
REQ-023 SHALL treat inputs with exponent field 0 as signed zero; denormals are flushed on input.
REQ-024 SHALL, when x2 is zero and x1 is nonzero, give y = sign|0x7F800000 and ovf=1.
REQ-025 SHALL, when x1 is zero (including 0/0), give y = signed zero with ovf=0 and unf=0.
REQ-026 SHALL, when the final exponent is 255 or more, give y = sign|0x7F800000 and ovf=1.
REQ-027 SHALL, when the final exponent is 0 or less, give y = signed zero and unf=1; no denormal outputs are produced.
REQ-028 SHALL still take the full 29-cycle latency for every special case, including zero and divide-by-zero.
REQ-029 SHALL hold y, ovf and unf from ROUND until the next ROUND; they update only there.
REQ-030 SHALL leave y unspecified for inputs with exponent field 255, while done timing remains per REQ-017.

Reset
REQ-031 SHALL, while rst=1, asynchronously force the state to IDLE and set y=0, ovf=0, unf=0, busy=0 and done=0.
REQ-032 SHALL discard any division in progress when rst is asserted mid-operation, with no done pulse for it.
REQ-033 SHALL honour start from the first rising edge after rst deasserts.

Verification
REQ-034 SHALL be verified with x1=0x40C00000, x2=0x40000000, start for 1 cycle -> done in cycle 29, y=0x40400000, ovf=0, unf=0.
REQ-035 SHALL be verified with x1=0x3F800000, x2=0x40400000 -> y=0x3EAAAAAB (RNE rounds up), flags 0.
REQ-036 SHALL be verified with x1=0xC0000000, x2=0x00000000 -> y=0xFF800000, ovf=1; then x1=0x7F000000, x2=0x3E800000 -> y=0x7F800000, ovf=1.
REQ-037 SHALL be verified with x1=0x00800000, x2=0x40000000 -> y=0x00000000, unf=1, ovf=0.
REQ-038 SHALL be verified with start pulsed again in cycle 5 using different operands -> ignored; first result unchanged and exactly one done pulse.
REQ-039 SHALL be verified with rst asserted in cycle 10 of an operation -> busy=0 and y=0 immediately, no done; a new start after release completes normally in 29 cycles.
